// File: rtl/gppm_display_pkg.sv
// -----------------------------------------------------------------------------
// gppm_display_pkg
// Shared definitions for the result display slice:
//   - NUM_DIGITS / BIN_W / BCD_W : sizes of the binary input and BCD result
//   - SEG_BLANK, SEG_DIGIT[0:9]  : active-low seven-segment glyphs {g,f,e,d,c,b,a}
//   - conv_state_t               : double-dabble conversion states
//   - dd_adjust()                : add-3 correction applied before each shift
//   - seg_glyph()                : nibble to glyph lookup, blank when out of range
// -----------------------------------------------------------------------------
package gppm_display_pkg;

   localparam int NUM_DIGITS = 3;
   localparam int BIN_W      = 8;
   localparam int BCD_W      = 4 * NUM_DIGITS;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'b1000000,   // 0
      7'b1111001,   // 1
      7'b0100100,   // 2
      7'b0110000,   // 3
      7'b0011001,   // 4
      7'b0010010,   // 5
      7'b0000010,   // 6
      7'b1111000,   // 7
      7'b0000000,   // 8
      7'b0010000    // 9
   };

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } conv_state_t;

   // Double-dabble correction: any BCD nibble of 5 or more gets 3 added so
   // that the following left shift carries correctly into the next decade.
   function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] scratch);
      logic [BCD_W-1:0] adj;
      adj = scratch;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (scratch[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
         end else begin
            adj[4*i +: 4] = scratch[4*i +: 4];
         end
      end
      return adj;
   endfunction

   // Glyph lookup; a nibble above 9 cannot come out of the converter but is
   // still mapped to a dark digit rather than garbage.
   function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
      logic [6:0] glyph;
      if (nib <= 4'd9) begin
         glyph = SEG_DIGIT[nib];
      end else begin
         glyph = SEG_BLANK;
      end
      return glyph;
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential double-dabble converter, one iteration per clock.
// When idle it watches `bin`; a value different from the last captured one is
// captured and converted over the next 8 edges, after which `bcd` is updated
// in a single step (it never shows partial digits).
//
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   asynchronous, active-high reset
//   bin    in   8   unsigned binary value to convert
//   bcd    out  12  registered BCD result {hundreds, tens, ones}
//   busy   out  1   high while a conversion is in progress
// -----------------------------------------------------------------------------
module bin_to_bcd_seq
   import gppm_display_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [BIN_W-1:0] bin,
   output logic [BCD_W-1:0] bcd,
   output logic             busy
);

   localparam logic [3:0] LAST_ITER = 4'(BIN_W - 1);

   conv_state_t      r_state;
   conv_state_t      w_state_nxt;

   logic [BIN_W-1:0] r_cap;
   logic [BIN_W-1:0] r_shift;
   logic [BCD_W-1:0] r_scratch;
   logic [3:0]       r_count;
   logic [BCD_W-1:0] r_bcd;
   logic             r_busy;

   logic [BIN_W-1:0] w_cap_nxt;
   logic [BIN_W-1:0] w_shift_nxt;
   logic [BCD_W-1:0] w_scratch_nxt;
   logic [3:0]       w_count_nxt;
   logic [BCD_W-1:0] w_bcd_nxt;
   logic             w_busy_nxt;

   logic [BCD_W-1:0] w_adj;
   logic [BCD_W-1:0] w_shifted;

   // Corrected scratch, then the scratch half of {scratch, shift} << 1.
   assign w_adj     = dd_adjust(r_scratch);
   assign w_shifted = {w_adj[BCD_W-2:0], r_shift[BIN_W-1]};

   // Conversion state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and datapath decode for the converter.
   always_comb begin
      w_state_nxt   = r_state;
      w_cap_nxt     = r_cap;
      w_shift_nxt   = r_shift;
      w_scratch_nxt = r_scratch;
      w_count_nxt   = r_count;
      w_bcd_nxt     = r_bcd;
      w_busy_nxt    = r_busy;

      case (r_state)
         IDLE: begin
            // Only a changed input starts work, so a steady input costs
            // nothing and res=0 right after reset is already "converted".
            if (bin != r_cap) begin
               w_cap_nxt     = bin;
               w_shift_nxt   = bin;
               w_scratch_nxt = {BCD_W{1'b0}};
               w_count_nxt   = 4'd0;
               w_busy_nxt    = 1'b1;
               w_state_nxt   = SHIFT;
            end else begin
               w_state_nxt   = IDLE;
            end
         end

         SHIFT: begin
            w_scratch_nxt = w_shifted;
            w_shift_nxt   = {r_shift[BIN_W-2:0], 1'b0};
            w_count_nxt   = r_count + 4'd1;
            // Eighth iteration: publish the fully shifted scratch directly.
            if (r_count == LAST_ITER) begin
               w_bcd_nxt   = w_shifted;
               w_busy_nxt  = 1'b0;
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = SHIFT;
            end
         end

         default: begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Converter datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cap     <= {BIN_W{1'b0}};
         r_shift   <= {BIN_W{1'b0}};
         r_scratch <= {BCD_W{1'b0}};
         r_count   <= 4'd0;
         r_bcd     <= {BCD_W{1'b0}};
         r_busy    <= 1'b0;
      end else begin
         r_cap     <= w_cap_nxt;
         r_shift   <= w_shift_nxt;
         r_scratch <= w_scratch_nxt;
         r_count   <= w_count_nxt;
         r_bcd     <= w_bcd_nxt;
         r_busy    <= w_busy_nxt;
      end
   end

   assign bcd  = r_bcd;
   assign busy = r_busy;

endmodule

// File: rtl/result_display.sv
// -----------------------------------------------------------------------------
// result_display
// Takes the adder's 8-bit result, converts it to three BCD digits and scans
// them onto a common-anode, multiplexed seven-segment display.
//
// Parameters:
//   REFRESH_DIV  clocks each digit slot stays lit (16 in sim, 100000 on board)
//   BLANK_LZ     1 = dark leading-zero digits, 0 = always show three digits
//
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   asynchronous, active-high reset
//   res    in   8   unsigned result from the adder stage
//   bcd    out  12  registered BCD value {hundreds, tens, ones}
//   busy   out  1   high while a conversion is in progress
//   an     out  4   digit enables, active-low; an[0]=ones, an[3] always 1
//   seg    out  7   segments, active-low, {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module result_display
   import gppm_display_pkg::*;
#(
   parameter int REFRESH_DIV = 16,
   parameter int BLANK_LZ    = 1
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [BIN_W-1:0] res,
   output logic [BCD_W-1:0] bcd,
   output logic             busy,
   output logic [3:0]       an,
   output logic [6:0]       seg
);

   localparam int               REF_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

   logic [BCD_W-1:0] w_bcd;
   logic             w_busy;

   logic [REF_W-1:0] r_refresh;
   logic [1:0]       r_digit;
   logic [3:0]       r_an;
   logic [6:0]       r_seg;

   logic [3:0]       w_hund;
   logic [3:0]       w_tens;
   logic [3:0]       w_ones;
   logic [3:0]       w_nib;
   logic [3:0]       w_an_sel;
   logic             w_blank;
   logic [3:0]       w_an_nxt;
   logic [6:0]       w_seg_nxt;

   bin_to_bcd_seq u_conv (
      .clk   (clk),
      .reset (reset),
      .bin   (res),
      .bcd   (w_bcd),
      .busy  (w_busy)
   );

   assign w_hund = w_bcd[11:8];
   assign w_tens = w_bcd[7:4];
   assign w_ones = w_bcd[3:0];

   // Slot timer and digit index: the index steps ones -> tens -> hundreds.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_refresh <= {REF_W{1'b0}};
         r_digit   <= 2'd0;
      end else begin
         if (r_refresh == REF_LAST) begin
            r_refresh <= {REF_W{1'b0}};
            if (r_digit == 2'(NUM_DIGITS - 1)) begin
               r_digit <= 2'd0;
            end else begin
               r_digit <= r_digit + 2'd1;
            end
         end else begin
            r_refresh <= r_refresh + REF_W'(1);
            r_digit   <= r_digit;
         end
      end
   end

   // Digit select, anode pattern and leading-zero blanking for the current slot.
   always_comb begin
      w_nib     = w_ones;
      w_an_sel  = 4'b1111;
      w_blank   = 1'b0;
      w_an_nxt  = 4'b1111;
      w_seg_nxt = SEG_BLANK;

      case (r_digit)
         2'd0: begin
            w_nib    = w_ones;
            w_an_sel = 4'b1110;
            w_blank  = 1'b0;
         end
         2'd1: begin
            w_nib    = w_tens;
            w_an_sel = 4'b1101;
            // Tens is only a leading zero when hundreds is zero as well.
            w_blank  = (BLANK_LZ != 0) && (w_hund == 4'd0) && (w_tens == 4'd0);
         end
         2'd2: begin
            w_nib    = w_hund;
            w_an_sel = 4'b1011;
            w_blank  = (BLANK_LZ != 0) && (w_hund == 4'd0);
         end
         default: begin
            w_nib    = 4'd0;
            w_an_sel = 4'b1111;
            w_blank  = 1'b1;
         end
      endcase

      // A blank slot keeps its time share but lights nothing.
      if (w_blank) begin
         w_an_nxt  = 4'b1111;
         w_seg_nxt = SEG_BLANK;
      end else begin
         w_an_nxt  = w_an_sel;
         w_seg_nxt = seg_glyph(w_nib);
      end
   end

   // Registered display drive; shows the slot selected on the previous edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_an  <= 4'b1111;
         r_seg <= SEG_BLANK;
      end else begin
         r_an  <= w_an_nxt;
         r_seg <= w_seg_nxt;
      end
   end

   assign bcd  = w_bcd;
   assign busy = w_busy;
   assign an   = r_an;
   assign seg  = r_seg;

endmodule

// File: tb/tb_result_display.sv
module tb_result_display;

   localparam int RDIV = 16;

   localparam logic [6:0] GLYPH [0:9] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  res   = 8'd0;

   logic [11:0] bcd,  bcd_nb;
   logic        busy, busy_nb;
   logic [3:0]  an,   an_nb;
   logic [6:0]  seg,  seg_nb;

   int vectors     = 0;
   int miscompares = 0;
   int edge_cnt;
   logic [11:0] exp_bcd = 12'h000;
   int          cap     = 0;

   result_display #(.REFRESH_DIV(RDIV), .BLANK_LZ(1)) dut (
      .clk(clk), .reset(reset), .res(res),
      .bcd(bcd), .busy(busy), .an(an), .seg(seg)
   );

   result_display #(.REFRESH_DIV(RDIV), .BLANK_LZ(0)) dut_nb (
      .clk(clk), .reset(reset), .res(res),
      .bcd(bcd_nb), .busy(busy_nb), .an(an_nb), .seg(seg_nb)
   );

   always #5 clk = ~clk;

   // Number of rising edges since reset was released.
   always @(posedge clk or posedge reset) begin
      if (reset) edge_cnt <= 0;
      else       edge_cnt <= edge_cnt + 1;
   end

   function automatic logic [11:0] model_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Expected {an, seg} after edge k for a stable value v.
   function automatic logic [10:0] model_disp(input int v, input int k, input bit blank);
      int slot = ((k - 1) / RDIV) % 3;
      int h = v / 100;
      int t = (v / 10) % 10;
      int o = v % 10;
      int d;
      bit dark;
      logic [3:0] a;
      d = (slot == 0) ? o : ((slot == 1) ? t : h);
      dark = blank && ((slot == 2 && h == 0) || (slot == 1 && h == 0 && t == 0));
      if (dark) return {4'b1111, 7'b1111111};
      a = 4'b1111 & ~(4'b0001 << slot);
      return {a, GLYPH[d]};
   endfunction

   task automatic test_scan(input string name, input int v, input int cycles);
      logic [10:0] e;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         e = model_disp(v, edge_cnt, 1'b1);
         vectors++;
         if ({an, seg} !== e) begin
            miscompares++;
            $display("FAIL %s_scan_lz k=%0d: an/seg=%b/%b required %b/%b",
                     name, edge_cnt, an, seg, e[10:7], e[6:0]);
         end
         e = model_disp(v, edge_cnt, 1'b0);
         vectors++;
         if ({an_nb, seg_nb} !== e) begin
            miscompares++;
            $display("FAIL %s_scan_nolz k=%0d: an/seg=%b/%b required %b/%b",
                     name, edge_cnt, an_nb, seg_nb, e[10:7], e[6:0]);
         end
      end
   endtask

   task automatic test_convert(input int v, input string name);
      int hi = 0;
      logic [11:0] prev = exp_bcd;
      res = 8'(v);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy !== 1'b1) break;
         hi++;
         vectors++;
         if (bcd !== prev) begin
            miscompares++;
            $display("FAIL %s_hold: bcd=%h required %h while busy", name, bcd, prev);
         end
      end
      vectors++;
      if (hi != 8) begin
         miscompares++;
         $display("FAIL %s_busy_len: busy cycles=%0d required 8", name, hi);
      end
      exp_bcd = model_bcd(v);
      cap = v;
      vectors++;
      if (bcd !== exp_bcd || bcd_nb !== exp_bcd) begin
         miscompares++;
         $display("FAIL %s_bcd: bcd=%h/%h required %h (res=%0d)", name, bcd, bcd_nb, exp_bcd, v);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      res   = 8'd0;
      repeat (3) begin
         @(negedge clk);
         vectors++;
         if (bcd !== 12'h000 || busy !== 1'b0 || an !== 4'b1111 || seg !== 7'b1111111) begin
            miscompares++;
            $display("FAIL reset_state: bcd=%h busy=%b an=%b seg=%b required 000/0/1111/1111111",
                     bcd, busy, an, seg);
         end
      end
      reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (an !== 4'b1110 || seg !== 7'b1000000) begin
         miscompares++;
         $display("FAIL reset_first_scan: an=%b seg=%b required 1110/1000000", an, seg);
      end
      for (int i = 0; i < 3 * RDIV + 5; i++) begin
         @(negedge clk);
         vectors++;
         if (busy !== 1'b0 || bcd !== 12'h000 || an[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b bcd=%h an=%b required 0/000/1xxx", busy, bcd, an);
         end
      end
      test_scan("reset", 0, 2 * RDIV);
   endtask

   task automatic test_max();
      test_convert(255, "max");
      test_scan("max", 255, 3 * RDIV + 4);
   endtask

   task automatic test_blanking();
      test_convert(7, "blank7");
      test_scan("blank7", 7, 3 * RDIV + 4);
      test_convert(40, "blank40");
      test_scan("blank40", 40, 3 * RDIV + 4);
   endtask

   task automatic test_change_busy();
      int hi = 0;
      res = 8'd100;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL chg_start: busy=%b required 1", busy);
         end
         hi++;
      end
      res = 8'd42;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy !== 1'b1) break;
         hi++;
      end
      vectors++;
      if (hi != 8 || bcd !== 12'h100) begin
         miscompares++;
         $display("FAIL chg_stale: busy cycles=%0d bcd=%h required 8/100", hi, bcd);
      end
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy !== 1'b1) break;
         hi++;
         vectors++;
         if (bcd !== 12'h100) begin
            miscompares++;
            $display("FAIL chg_hold: bcd=%h required 100", bcd);
         end
      end
      vectors++;
      if (hi != 8 || bcd !== 12'h042) begin
         miscompares++;
         $display("FAIL chg_new: busy cycles=%0d bcd=%h required 8/042", hi, bcd);
      end
      exp_bcd = 12'h042;
      cap = 42;
   endtask

   task automatic test_reset_mid();
      res = 8'd199;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1;
      vectors++;
      if (busy !== 1'b0 || bcd !== 12'h000 || an !== 4'b1111 || seg !== 7'b1111111 ||
          busy_nb !== 1'b0 || bcd_nb !== 12'h000 || an_nb !== 4'b1111) begin
         miscompares++;
         $display("FAIL mid_reset: busy=%b bcd=%h an=%b seg=%b required 0/000/1111/1111111",
                  busy, bcd, an, seg);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         vectors++;
         if (i < 9) begin
            if (busy !== 1'b1 || bcd !== 12'h000) begin
               miscompares++;
               $display("FAIL mid_restart e%0d: busy=%b bcd=%h required 1/000", i, busy, bcd);
            end
         end else begin
            if (busy !== 1'b0 || bcd !== 12'h199) begin
               miscompares++;
               $display("FAIL mid_done: busy=%b bcd=%h required 0/199", busy, bcd);
            end
         end
      end
      exp_bcd = 12'h199;
      cap = 199;
   endtask

   task automatic test_sweep();
      for (int v = 0; v < 256; v++) test_convert(v, "sweep");
   endtask

   task automatic test_random();
      int v;
      for (int n = 0; n < 40; n++) begin
         v = int'($urandom_range(0, 255));
         repeat (int'($urandom_range(0, 3))) @(negedge clk);
         if (v == cap) begin
            res = 8'(v);
            repeat (3) begin
               @(negedge clk);
               vectors++;
               if (busy !== 1'b0 || bcd !== exp_bcd) begin
                  miscompares++;
                  $display("FAIL rand_same: busy=%b bcd=%h required 0/%h", busy, bcd, exp_bcd);
               end
            end
         end else begin
            test_convert(v, "rand");
         end
         if (n % 8 == 0) test_scan("rand", cap, int'($urandom_range(5, 20)));
      end
   endtask

   initial begin
      test_reset();
      test_max();
      test_blanking();
      test_change_busy();
      test_reset_mid();
      test_sweep();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
